// File: rtl/stream_mux_2to1_pkg.sv
// Shared types and constants for the 2:1 packet-aware stream multiplexer.
// Holds the FSM state encoding, the default data width and a small lock-state helper.
package stream_mux_2to1_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOCK0 = 2'b01,
    LOCK1 = 2'b10
  } state_e;

  // Lock state that pins the grant to the given source until its last beat.
  function automatic state_e lock_state(input logic src);
    return src ? LOCK1 : LOCK0;
  endfunction

endpackage

// File: rtl/stream_mux_2to1_arbiter.sv
// Combinational two-source round-robin arbiter with packet lock.
// In IDLE it grants by valid and rr priority; in LOCKx the grant stays pinned to source x.
module rr_arbiter_2
  import stream_mux_2to1_pkg::*;
(
  input  logic [1:0] state,
  input  logic       rr,
  input  logic       in0_valid,
  input  logic       in1_valid,
  output logic       grant,
  output logic       grant_valid
);

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    grant       = 1'b0;
    grant_valid = 1'b0;
    unique case (state)
      LOCK0: begin
        grant       = 1'b0;
        grant_valid = in0_valid;
      end
      LOCK1: begin
        grant       = 1'b1;
        grant_valid = in1_valid;
      end
      default: begin
        if (in0_valid && in1_valid) begin
          grant       = rr;
          grant_valid = 1'b1;
        end else if (in0_valid) begin
          grant       = 1'b0;
          grant_valid = 1'b1;
        end else if (in1_valid) begin
          grant       = 1'b1;
          grant_valid = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/stream_mux_2to1.sv
// Two-source packet multiplexer with a one-entry registered output stage.
// Packets never interleave: a source that starts a packet holds the grant until its last beat.
module stream_mux_2to1
  import stream_mux_2to1_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             in0_valid,
  input  logic             in0_last,
  input  logic [WIDTH-1:0] in0_data,
  output logic             in0_ready,

  input  logic             in1_valid,
  input  logic             in1_last,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,

  output logic             out_valid,
  output logic             out_last,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready
);

  state_e           r_state;
  state_e           w_state_next;
  logic             r_rr;
  logic             w_rr_next;

  logic             r_out_valid;
  logic             r_out_last;
  logic             r_out_src;
  logic [WIDTH-1:0] r_out_data;

  logic             w_grant;
  logic             w_grant_valid;
  logic             w_can_accept;
  logic             w_accept;
  logic             w_sel_last;
  logic [WIDTH-1:0] w_sel_data;

  rr_arbiter_2 u_arbiter (
    .state       (r_state),
    .rr          (r_rr),
    .in0_valid   (in0_valid),
    .in1_valid   (in1_valid),
    .grant       (w_grant),
    .grant_valid (w_grant_valid)
  );

  // The output slot is free when empty or being drained this same cycle.
  assign w_can_accept = !r_out_valid || out_ready;
  assign w_accept     = !rst && w_can_accept && w_grant_valid;
  assign in0_ready    = w_accept && !w_grant;
  assign in1_ready    = w_accept &&  w_grant;

  assign w_sel_last   = w_grant ? in1_last : in0_last;
  assign w_sel_data   = w_grant ? in1_data : in0_data;

  always_comb begin
    w_state_next = r_state;
    w_rr_next    = r_rr;
    if (w_accept) begin
      if (w_sel_last) begin
        w_state_next = IDLE;
        w_rr_next    = ~w_grant;
      end else begin
        w_state_next = lock_state(w_grant);
      end
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rr    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_rr    <= w_rr_next;
    end
  end

  // Payload holds after a drain so the bus only toggles on real transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_src   <= 1'b0;
      r_out_data  <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_last  <= w_sel_last;
      r_out_src   <= w_grant;
      r_out_data  <= w_sel_data;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_src   = r_out_src;
  assign out_data  = r_out_data;

endmodule
